// File: rtl/sobel_stream_ctrl.sv
// Frame sequencer for the Sobel window loader: raster memory reads, one-entry hold
// buffer feeding the loader, and a valid/ready window output that stalls the whole pipe.
module sobel_stream_ctrl #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic              Mem_Rd,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic [7:0]        Mem_Data,
  output logic              Ld_Reset,
  output logic              Ld_Enable,
  output logic [7:0]        Ld_Data,
  input  logic              Ld_isReady,
  input  logic              Ld_isEnd,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [ADDR_W-1:0] Out_Addr
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  rd_cnt;
  logic [ADDR_W-1:0] out_cnt;
  logic              busy_r;
  logic              done_r;
  logic              init_r;
  logic              fresh;
  logic              hold_valid;
  logic [7:0]        hold_data;
  logic              win_new;
  logic              stall;
  logic              accept;

  assign Out_Valid = win_new & Ld_isReady;
  assign stall     = Out_Valid & ~Out_Ready;
  assign accept    = Out_Valid & Out_Ready;
  assign Mem_Rd    = (state == RUN) & ~stall & (rd_cnt < CNT_W'(TOTAL));
  assign Mem_Addr  = ADDR_W'(rd_cnt);
  assign Ld_Enable = hold_valid & ~stall;
  // Read data is forwarded in its arrival cycle; the hold copy only serves stalled cycles.
  assign Ld_Data   = fresh ? Mem_Data : hold_data;
  assign Ld_Reset  = Reset | init_r;
  assign Busy      = busy_r;
  assign Done      = done_r;
  assign Out_Addr  = out_cnt;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      out_cnt <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      init_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      init_r <= 1'b0;
      if (accept) out_cnt <= out_cnt + 1'b1;
      case (state)
        IDLE: if (Start) begin
          state  <= INIT;
          busy_r <= 1'b1;
          init_r <= 1'b1;
        end
        INIT: begin
          rd_cnt  <= '0;
          out_cnt <= '0;
          state   <= RUN;
        end
        RUN: begin
          if (Mem_Rd) rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == CNT_W'(TOTAL)) state <= DRAIN;
        end
        DRAIN: if (!hold_valid && Ld_isEnd && !Out_Valid) begin
          state  <= DONE;
          done_r <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reads and loader advances share the same ~stall gate, so one hold entry never overflows.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fresh      <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      win_new    <= 1'b0;
    end else begin
      fresh      <= Mem_Rd;
      hold_valid <= Mem_Rd | (hold_valid & ~Ld_Enable);
      if (fresh) hold_data <= Mem_Data;
      if (Ld_Enable)
        win_new <= 1'b1;
      else if (accept || !Ld_isReady)
        win_new <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Self-checking bench: behavioural memory and 3x3 loader around the sequencer, with
// every accepted window compared against windows cut straight from the source image.
module tb_sobel_stream_ctrl;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int AW   = 16;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 2) * (H - 2);

  logic          CLK = 1'b0;
  logic          Reset;
  logic          Start;
  logic          Busy;
  logic          Done;
  logic          Mem_Rd;
  logic [AW-1:0] Mem_Addr;
  logic [7:0]    Mem_Data;
  logic          Ld_Reset;
  logic          Ld_Enable;
  logic [7:0]    Ld_Data;
  logic          Ld_isReady;
  logic          Ld_isEnd;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [AW-1:0] Out_Addr;

  logic [7:0] img    [NPIX];
  logic [7:0] ld_pix [NPIX];
  int         ld_count;

  int checks = 0;
  int errors = 0;
  int rd_seen, res_seen, done_seen, ldrst_seen, frame_cycles;
  int ready_mode, stall_left;
  bit stall_used;

  sobel_stream_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Busy(Busy), .Done(Done),
    .Mem_Rd(Mem_Rd), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data),
    .Ld_Reset(Ld_Reset), .Ld_Enable(Ld_Enable), .Ld_Data(Ld_Data),
    .Ld_isReady(Ld_isReady), .Ld_isEnd(Ld_isEnd),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Addr(Out_Addr)
  );

  always #5 CLK = ~CLK;

  // One-cycle-latency read memory.
  always_ff @(posedge CLK) begin
    if (Mem_Rd) Mem_Data <= img[int'(Mem_Addr) % NPIX];
  end

  // Loader: stores pixels in arrival order; a window is ready once row and col reach 2.
  always_ff @(posedge CLK) begin
    if (Ld_Reset) ld_count <= 0;
    else if (Ld_Enable && ld_count < NPIX) begin
      ld_pix[ld_count] <= Ld_Data;
      ld_count         <= ld_count + 1;
    end
  end

  always_comb begin
    Ld_isReady = 1'b0;
    if (ld_count > 0)
      Ld_isReady = ((ld_count - 1) / W >= 2) && ((ld_count - 1) % W >= 2);
    Ld_isEnd = (ld_count == NPIX);
  end

  function automatic logic [71:0] refWindow(input int k);
    logic [71:0] v = '1;
    if (k >= 0 && k < NWIN) begin
      int r = 1 + k / (W - 2);
      int c = 1 + k % (W - 2);
      v = '0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          v = {v[63:0], img[(r + dr) * W + c + dc]};
    end
    return v;
  endfunction

  function automatic logic [71:0] loaderWindow();
    logic [71:0] v = '0;
    int r = (ld_count - 1) / W;
    int c = (ld_count - 1) % W;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        int idx = (r - 2 + dr) * W + c - 2 + dc;
        v = {v[63:0], (idx >= 0 && idx < NPIX) ? ld_pix[idx] : 8'h00};
      end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [79:0] observed,
                             input logic [79:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle at the falling edge, then observe the settled outputs before the next rise.
  task automatic applyStimulus(input bit start);
    @(negedge CLK);
    Start = start;
    case (ready_mode)
      0: Out_Ready = 1'b1;
      1: Out_Ready = 1'($urandom_range(0, 1));
      default: begin
        if (!stall_used && Out_Valid) begin
          stall_used = 1'b1;
          stall_left = 5;
        end
        if (stall_left > 0) begin
          Out_Ready = 1'b0;
          stall_left--;
        end else Out_Ready = 1'b1;
      end
    endcase
    #1;
    if (Ld_Reset) ldrst_seen++;
    if (Done) done_seen++;
    if (Mem_Rd) begin
      checkOutput("mem_addr", 80'(Mem_Addr), 80'(rd_seen));
      rd_seen++;
    end
    if (Out_Valid && !Out_Ready)
      checkOutput("stall_freeze", 80'({Mem_Rd, Ld_Enable}), 80'(0));
    if (Out_Valid && Out_Ready) begin
      checkOutput("out_addr", 80'(Out_Addr), 80'(res_seen));
      checkOutput("window", 80'(loaderWindow()), 80'(refWindow(res_seen)));
      res_seen++;
    end
  endtask

  task automatic beginFrame(input int mode);
    ready_mode = mode;
    stall_used = 1'b0;
    stall_left = 0;
    rd_seen    = 0;
    res_seen   = 0;
    done_seen  = 0;
    ldrst_seen = 0;
    frame_cycles = 0;
    applyStimulus(1'b1);
    checkOutput("start_idle", 80'(Busy), 80'(0));
  endtask

  task automatic runFrame(input int mode, input bit spam, input int exp_cycles);
    beginFrame(mode);
    for (int i = 0; i < 400 && done_seen == 0; i++) begin
      applyStimulus(spam);
      frame_cycles++;
      checkOutput("busy", 80'(Busy), 80'(1));
    end
    checkOutput("done_seen", 80'(done_seen), 80'(1));
    checkOutput("results", 80'(res_seen), 80'(NWIN));
    checkOutput("reads", 80'(rd_seen), 80'(NPIX));
    checkOutput("ld_reset_pulses", 80'(ldrst_seen), 80'(1));
    if (exp_cycles > 0)
      checkOutput("frame_cycles", 80'(frame_cycles), 80'(exp_cycles));
  endtask

  task automatic loadRamp();
    for (int i = 0; i < NPIX; i++) img[i] = 8'(i);
  endtask

  task automatic loadRandom();
    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Out_Ready = 1'b0;
    ready_mode = 0;
    loadRamp();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    checkOutput("rst_outputs", 80'({Busy, Done, Mem_Rd, Mem_Addr, Ld_Enable, Ld_Data,
                                    Out_Valid, Out_Addr}), 80'(0));
    checkOutput("rst_ld_reset", 80'(Ld_Reset), 80'(1));
    @(negedge CLK);
    Reset = 1'b0;

    $display("[TB] ramp frame, Out_Ready high");
    runFrame(0, 1'b0, 21);

    $display("[TB] ramp frame, 5-cycle stall at first result");
    runFrame(2, 1'b0, 26);

    $display("[TB] random images, random Out_Ready");
    for (int f = 0; f < 20; f++) begin
      loadRandom();
      runFrame(1, 1'b0, 0);
    end

    $display("[TB] Start pulsed through the whole frame and in DONE");
    loadRamp();
    runFrame(0, 1'b1, 21);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0);
      checkOutput("post_done_idle", 80'({Busy, Done, Mem_Rd}), 80'(0));
    end

    $display("[TB] reset after 7 reads");
    beginFrame(0);
    for (int i = 0; i < 50 && rd_seen < 7; i++) applyStimulus(1'b0);
    checkOutput("reads_before_reset", 80'(rd_seen), 80'(7));
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    checkOutput("async_rst_outputs", 80'({Busy, Done, Mem_Rd, Mem_Addr, Ld_Enable, Ld_Data,
                                          Out_Valid, Out_Addr}), 80'(0));
    checkOutput("async_rst_ld_reset", 80'(Ld_Reset), 80'(1));
    @(negedge CLK);
    Reset = 1'b0;
    runFrame(0, 1'b0, 21);

    $display("[TB] back-to-back frames");
    loadRandom();
    runFrame(0, 1'b0, 21);
    runFrame(0, 1'b0, 21);
    loadRamp();
    runFrame(1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
